// File: rtl/store_merge_unit.sv
// store_merge_unit
//
// Store path into a word-only data memory that has no byte enables.
// A word store goes straight to a single write cycle. A byte store runs a
// read-modify-write: it reads the aligned word, replaces one byte lane with
// WriteData[7:0] and writes the merged word back.
//
// Request handshake: Start is the request valid and (state == IDLE), the
// inverse of Busy, is the ready. A request transfers on a rising edge where
// Start=1 and the unit is idle. Start seen while Busy is dropped, not queued.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   Start      store request, sampled only in IDLE
//   Addr       byte address; [1:0] selects the byte lane
//   WriteData  store data; byte stores use [7:0]
//   DataType   1 = word store, 0 = byte store
//   MemRData   memory read data, valid the cycle after MemRE
//   MemAddr    word-aligned memory address (zero when no access)
//   MemWData   word written to memory (zero outside WRITE)
//   MemRE      memory read strobe
//   MemWE      memory write strobe
//   Busy       high whenever the unit is not IDLE
//   Done       one-cycle completion pulse
//   AlignErr   pulses with Done for a word store with Addr[1:0] != 0
//   dbg_state  current FSM state, for observation only
module store_merge_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WriteData,
  input  logic                  DataType,
  input  logic [31:0]           MemRData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemWData,
  output logic                  MemRE,
  output logic                  MemWE,
  output logic                  Busy,
  output logic                  Done,
  output logic                  AlignErr,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  // Request registers, loaded only when a request is accepted in IDLE.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  dtype_q;
  logic                  misalign_q;
  logic [31:0]           merge_q;

  logic [31:0]           merged;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  // Word stores ignore the low address bits entirely: always aligned.
  assign aligned_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Byte-lane replacement on the word returned by the READ cycle.
  always_comb begin
    merged = MemRData;
    case (addr_q[1:0])
      2'b00:   merged[7:0]   = wdata_q[7:0];
      2'b01:   merged[15:8]  = wdata_q[7:0];
      2'b10:   merged[23:16] = wdata_q[7:0];
      default: merged[31:24] = wdata_q[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      dtype_q    <= 1'b0;
      misalign_q <= 1'b0;
      merge_q    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && Start) begin
        addr_q     <= Addr;
        wdata_q    <= WriteData;
        dtype_q    <= DataType;
        misalign_q <= DataType & (|Addr[1:0]);
      end
      // MemRData is valid in MERGE, one cycle after the READ strobe.
      if (state == MERGE) begin
        merge_q <= merged;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = DataType ? WRITE : READ;
        end
      end
      READ:    state_next = MERGE;
      MERGE:   state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on state and the request registers, so no input
  // has a combinational path to any output.
  always_comb begin
    MemAddr  = '0;
    MemWData = '0;
    MemRE    = 1'b0;
    MemWE    = 1'b0;
    Done     = 1'b0;
    AlignErr = 1'b0;
    case (state)
      READ: begin
        MemRE   = 1'b1;
        MemAddr = aligned_addr;
      end
      WRITE: begin
        MemWE    = 1'b1;
        MemAddr  = aligned_addr;
        MemWData = dtype_q ? wdata_q : merge_q;
      end
      DONE: begin
        Done     = 1'b1;
        AlignErr = misalign_q;
      end
      default: ;
    endcase
  end

  assign Busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        DataType;
  logic [31:0] MemRData;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemRE;
  logic        MemWE;
  logic        Busy;
  logic        Done;
  logic        AlignErr;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  store_merge_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Addr(Addr),
    .WriteData(WriteData), .DataType(DataType), .MemRData(MemRData),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRE(MemRE), .MemWE(MemWE),
    .Busy(Busy), .Done(Done), .AlignErr(AlignErr), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory (bench owned, 256 words) ----------------
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int wr_count   = 0;
  int done_count = 0;

  // Read data appears the cycle after MemRE; other cycles return noise.
  always @(posedge clk) begin
    if (MemRE) MemRData <= mem[MemAddr[9:2]];
    else       MemRData <= $urandom;
    if (MemWE) begin
      mem[MemAddr[9:2]] = MemWData;
      wr_count++;
    end
    if (Done) done_count++;
  end

  always @(negedge clk) begin
    check("re_we_exclusive", {31'd0, MemRE & MemWE}, 32'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Applies a store to the expected memory image and returns the word that
  // must be written.
  function automatic logic [31:0] model_store(input logic [31:0] a, input logic [31:0] wd,
                                              input logic dt);
    int idx;
    int sh;
    logic [31:0] w;
    idx = int'(a[9:2]);
    if (dt) begin
      w = wd;
    end else begin
      sh = 8 * int'(a[1:0]);
      w = (ref_mem[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    ref_mem[idx] = w;
    return w;
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one store starting from a negedge in IDLE and check its timeline.
  // poke=1 pulses a stray Start during the byte store's MERGE cycle.
  task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic dt,
                          input bit poke);
    logic [31:0] aa;
    logic [31:0] exp_w;
    int w0;
    int d0;
    aa = {a[31:2], 2'b00};
    w0 = wr_count;
    d0 = done_count;
    exp_w = model_store(a, wd, dt);
    Start = 1'b1; Addr = a; WriteData = wd; DataType = dt;
    step();
    // Scramble inputs: the unit must work from its own latched copy.
    Start = 1'b0; Addr = $urandom; WriteData = $urandom; DataType = 1'($urandom);
    if (dt) begin
      check("word_we",    MemWE, 1);
      check("word_re",    MemRE, 0);
      check("word_addr",  MemAddr, aa);
      check("word_data",  MemWData, exp_w);
      check("word_busy",  Busy, 1);
      check("word_done0", Done, 0);
      step();
      check("word_done",  Done, 1);
      check("word_align", AlignErr, {31'd0, |a[1:0]});
      check("word_we_off", MemWE, 0);
      check("word_busy2", Busy, 1);
      step();
    end else begin
      check("byte_re",    MemRE, 1);
      check("byte_we0",   MemWE, 0);
      check("byte_raddr", MemAddr, aa);
      check("byte_busy",  Busy, 1);
      check("byte_done0", Done, 0);
      step();
      check("byte_merge_re", MemRE, 0);
      check("byte_merge_we", MemWE, 0);
      check("byte_busy2",    Busy, 1);
      if (poke) begin
        Start = 1'b1; DataType = 1'b1; Addr = 32'h3F0; WriteData = 32'hBAD0BAD0;
      end
      step();
      Start = 1'b0;
      check("byte_we",    MemWE, 1);
      check("byte_re_off", MemRE, 0);
      check("byte_waddr", MemAddr, aa);
      check("byte_wdata", MemWData, exp_w);
      step();
      check("byte_done",  Done, 1);
      check("byte_align", AlignErr, 0);
      check("byte_we_off", MemWE, 0);
      step();
    end
    check("idle_busy", Busy, 0);
    check("idle_done", Done, 0);
    check("one_write", wr_count - w0, 1);
    check("one_done",  done_count - d0, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] lane_exp [4];
    logic [31:0] ra;
    int w0;
    int d0;
    lane_exp[0] = 32'h112233AA;
    lane_exp[1] = 32'h1122AA44;
    lane_exp[2] = 32'h11AA3344;
    lane_exp[3] = 32'hAA223344;

    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    reset = 1'b1; Start = 1'b0; Addr = '0; WriteData = '0; DataType = 1'b0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      check("rst_busy",  Busy, 0);
      check("rst_re",    MemRE, 0);
      check("rst_we",    MemWE, 0);
      check("rst_done",  Done, 0);
      check("rst_align", AlignErr, 0);
      check("rst_addr",  MemAddr, 0);
      check("rst_wdata", MemWData, 0);
      check("rst_state", {29'd0, dbg_state}, 0);
      step();
    end

    // Aligned word store.
    do_store(32'h100, 32'hDEADBEEF, 1'b1, 1'b0);

    // Byte store into each lane of the same word, restored each time.
    for (int l = 0; l < 4; l++) begin
      set_word(32'h200 >> 2, 32'h11223344);
      do_store(32'h200 + l, 32'h000000AA, 1'b0, 1'b0);
      check("lane_word", mem[32'h200 >> 2], lane_exp[l]);
    end

    // Misaligned word store: forced aligned, data unrotated, AlignErr.
    do_store(32'h106, 32'hCAFEF00D, 1'b1, 1'b0);
    check("misalign_word", mem[32'h104 >> 2], 32'hCAFEF00D);

    // Start while busy is ignored.
    do_store(32'h2C1, 32'h0000005A, 1'b0, 1'b1);
    step();
    check("poke_ignored", Busy, 0);

    // Reset during MERGE of a byte store.
    w0 = wr_count;
    d0 = done_count;
    Start = 1'b1; Addr = 32'h303; WriteData = 32'h77; DataType = 1'b0;
    step();
    Start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", Busy, 0);
    check("midrst_re",   MemRE, 0);
    check("midrst_we",   MemWE, 0);
    check("midrst_done", Done, 0);
    for (int i = 0; i < 6; i++) step();
    check("midrst_nowrite", wr_count - w0, 0);
    check("midrst_nodone",  done_count - d0, 0);
    do_store(32'h104, 32'h12345678, 1'b1, 1'b0);

    // Reset and Start in the same cycle: request dropped.
    w0 = wr_count;
    reset = 1'b1; Start = 1'b1; Addr = 32'h10; WriteData = 32'h55; DataType = 1'b1;
    step();
    reset = 1'b0; Start = 1'b0;
    check("rst_start_busy", Busy, 0);
    step();
    step();
    check("rst_start_nowrite", wr_count - w0, 0);

    // Random back-to-back stores.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 1023);
      do_store(ra, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Whole memory image must match the reference model.
    for (int i = 0; i < 256; i++) check("mem_image", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
